// File: rtl/deser_pkg.sv
// deser_pkg: shared types and constants for the 3-wire serial receiver.
//   state_t     - receiver FSM states
//   SAMPLE_RISE - sample sd on synchronized sck 0->1
//   SAMPLE_FALL - sample sd on synchronized sck 1->0
//   cnt_bits()  - width of a counter that indexes WORD_WIDTH bits
package deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SAMPLE_RISE = 0;
  localparam int SAMPLE_FALL = 1;

  // Bits needed to hold 0..w-1; never less than one bit.
  function automatic int cnt_bits(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: single-bit multi-flop synchronizer for an asynchronous pin.
//   clk  - destination clock
//   rst  - asynchronous reset, active-high; chain loads RESET_VAL
//   i_d  - asynchronous input
//   o_q  - synchronized output, STAGES clk edges behind the pin
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {STAGES{RESET_VAL}};
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/deser.sv
// deser: serial-to-parallel receiver for the 3-wire link (sd, cs_n, sck).
//   clk, rst   - system clock, asynchronous active-high reset
//   sd, cs, sck- asynchronous link pins (cs active-low), MSB first
//   valid/ready/data - single-entry valid/ready source port for words
//   overrun    - sticky, a completed word was dropped; cleared by ovr_clr
//   frame_err  - one-cycle pulse when cs rises with a partial word
module deser
  import deser_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_EDGE = SAMPLE_RISE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sd,
  input  logic                  cs,
  input  logic                  sck,
  output logic                  valid,
  input  logic                  ready,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic                  frame_err
);

  localparam int             CW   = cnt_bits(WORD_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WORD_WIDTH - 1);

  // Synchronized pins. Identical chain depth keeps sd/cs/sck aligned
  // relative to each other, so setup of sd vs. the sck edge survives.
  logic w_sck_s, w_cs_s, w_sd_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .i_d(sck), .o_q(w_sck_s)
  );
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(cs), .o_q(w_cs_s)
  );
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sd (
    .clk(clk), .rst(rst), .i_d(sd), .o_q(w_sd_s)
  );

  logic r_sck_d;
  logic w_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sck_d <= 1'b0;
    else     r_sck_d <= w_sck_s;
  end

  generate
    if (SAMPLE_EDGE == SAMPLE_FALL) begin : g_fall
      assign w_sample = r_sck_d & ~w_sck_s;
    end else begin : g_rise
      assign w_sample = ~r_sck_d & w_sck_s;
    end
  endgenerate

  // Receive FSM
  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_bit_cnt, w_bit_cnt_n;
  logic [WORD_WIDTH-1:0] r_shift, w_shift_n;
  logic [WORD_WIDTH-1:0] w_shift_in;
  logic                  w_word_done;
  logic                  w_frame_err_n;

  // Word as it looks after this cycle's sample; used for loading the output
  // even when cs rises in the same cycle and the shifter gets cleared.
  assign w_shift_in = {r_shift[WORD_WIDTH-2:0], w_sd_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_shift   <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_shift_n     = r_shift;
    w_word_done   = 1'b0;
    w_frame_err_n = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_s) begin
          w_state_n   = SHIFT;
          w_bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        // Sample first, then look at cs: a last bit coinciding with the
        // cs rise still completes its word.
        if (w_sample) begin
          w_shift_n = w_shift_in;
          if (r_bit_cnt == LAST) begin
            w_word_done = 1'b1;
            w_bit_cnt_n = '0;
          end else begin
            w_bit_cnt_n = r_bit_cnt + CW'(1);
          end
        end
        if (w_cs_s) begin
          w_state_n     = IDLE;
          w_frame_err_n = (w_bit_cnt_n != '0);
          w_bit_cnt_n   = '0;
          w_shift_n     = '0;
        end
      end
      default: begin
        w_state_n   = IDLE;
        w_bit_cnt_n = '0;
        w_shift_n   = '0;
      end
    endcase
  end

  // Single-entry output register. A word that arrives while the slot is
  // full and not draining is dropped and flagged.
  logic                  r_valid;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_overrun;
  logic                  r_frame_err;
  logic                  w_load, w_drop;

  assign w_load = w_word_done & (~r_valid | ready);
  assign w_drop = w_word_done & r_valid & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_n;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_shift_in;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  assign valid     = r_valid;
  assign data      = r_data;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_deser.sv
// tb_deser: scoreboard bench for deser. Two instances share sck/cs; dut0
// samples on sck rise (sd0), dut1 on sck fall (sd1, launched after the rise).
module tb_deser;

  logic       clk = 1'b0;
  logic       rst, sd0, sd1, cs, sck, ready, ovr_clr;
  logic       valid0, valid1, ovr0, ovr1, fe0, fe1;
  logic [7:0] data0, data1;

  always #5 clk = ~clk;

  deser #(.WORD_WIDTH(8), .SYNC_STAGES(2), .SAMPLE_EDGE(0)) dut0 (
    .clk(clk), .rst(rst), .sd(sd0), .cs(cs), .sck(sck),
    .valid(valid0), .ready(ready), .data(data0),
    .overrun(ovr0), .ovr_clr(ovr_clr), .frame_err(fe0)
  );

  deser #(.WORD_WIDTH(8), .SYNC_STAGES(2), .SAMPLE_EDGE(1)) dut1 (
    .clk(clk), .rst(rst), .sd(sd1), .cs(cs), .sck(sck),
    .valid(valid1), .ready(ready), .data(data1),
    .overrun(ovr1), .ovr_clr(ovr_clr), .frame_err(fe1)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         beats0 = 0, beats1 = 0, fecnt0 = 0, fecnt1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a beat is a negedge where valid && ready; transfer is at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (fe0) fecnt0++;
      if (fe1) fecnt1++;
      if (valid0 && ready) begin
        beats0++;
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut0 unexpected word: got %0h expected none", data0);
        end else chk("dut0 data", data0, q0.pop_front());
      end
      if (valid1 && ready) begin
        beats1++;
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut1 unexpected word: got %0h expected none", data1);
        end else chk("dut1 data", data1, q1.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    q0.push_back(w);
    q1.push_back(w);
  endtask

  // Low phase lo cycles, high phase hi cycles (both >= 2).
  // sd0 is valid around the rise and corrupted during high; sd1 is launched
  // just after the rise and held through the fall.
  task automatic send_bits(input logic [7:0] w, input int nbits, input int lo, input int hi);
    for (int i = 0; i < nbits; i++) begin
      tick(1);
      sd0 = w[7-i];
      tick(lo - 1);
      sck = 1'b1;
      tick(1);
      sd1 = w[7-i];
      sd0 = ~w[7-i];
      tick(hi - 1);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    cs = 1'b1;
    tick(6);
  endtask

  int         b0, b1, p;
  logic [7:0] w;

  initial begin
    rst = 1'b1; sd0 = 1'b0; sd1 = 1'b0; cs = 1'b1; sck = 1'b0;
    ready = 1'b1; ovr_clr = 1'b0;
    tick(3);
    chk("reset valid0", valid0, 0);
    chk("reset data0", data0, 0);
    chk("reset ovr0", ovr0, 0);
    chk("reset fe0", fe0, 0);
    chk("reset valid1", valid1, 0);
    chk("reset data1", data1, 0);
    rst = 1'b0;
    tick(5);

    // 1: single word
    b0 = beats0; b1 = beats1;
    cs_low(); push(8'hA5); send_bits(8'hA5, 8, 4, 4); cs_high(); tick(20);
    chk("t1 beats0", beats0 - b0, 1);
    chk("t1 beats1", beats1 - b1, 1);
    chk("t1 ovr0", ovr0, 0);
    chk("t1 fe count", fecnt0 + fecnt1, 0);

    // 2: back-to-back words in one frame
    b0 = beats0;
    cs_low();
    push(8'h3C); send_bits(8'h3C, 8, 4, 4);
    push(8'hC3); send_bits(8'hC3, 8, 4, 4);
    cs_high(); tick(20);
    chk("t2 beats0", beats0 - b0, 2);
    chk("t2 fe count", fecnt0 + fecnt1, 0);

    // 3: overrun with ready low
    ready = 1'b0;
    cs_low();
    push(8'h11); send_bits(8'h11, 8, 4, 4);
    send_bits(8'h22, 8, 4, 4);
    cs_high(); tick(10);
    chk("t3 valid0", valid0, 1);
    chk("t3 data0", data0, 8'h11);
    chk("t3 ovr0", ovr0, 1);
    chk("t3 data1", data1, 8'h11);
    chk("t3 ovr1", ovr1, 1);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0; tick(1);
    chk("t3 ovr0 cleared", ovr0, 0);
    chk("t3 ovr1 cleared", ovr1, 0);
    b0 = beats0;
    ready = 1'b1; tick(5);
    chk("t3 drained beats0", beats0 - b0, 1);
    chk("t3 valid0 after drain", valid0, 0);

    // 4: truncated frame, then a good one
    fecnt0 = 0; fecnt1 = 0; b0 = beats0;
    cs_low(); send_bits(8'hFF, 5, 4, 4); cs_high(); tick(10);
    chk("t4 fe0 pulse cycles", fecnt0, 1);
    chk("t4 fe1 pulse cycles", fecnt1, 1);
    chk("t4 no beat", beats0 - b0, 0);
    cs_low(); push(8'h7E); send_bits(8'h7E, 8, 4, 4); cs_high(); tick(20);
    chk("t4 data0", data0, 8'h7E);
    chk("t4 data1", data1, 8'h7E);
    chk("t4 no new fe", fecnt0 + fecnt1, 2);

    // 5: async reset mid-frame with a pending word and overrun
    ready = 1'b0;
    cs_low();
    send_bits(8'h44, 8, 4, 4);
    send_bits(8'h55, 8, 4, 4);
    tick(5);
    chk("t5 pre ovr0", ovr0, 1);
    chk("t5 pre valid0", valid0, 1);
    send_bits(8'hFF, 3, 4, 4);
    #2 rst = 1'b1;
    #1;
    chk("t5 rst valid0", valid0, 0);
    chk("t5 rst ovr0", ovr0, 0);
    chk("t5 rst data0", data0, 0);
    chk("t5 rst valid1", valid1, 0);
    chk("t5 rst ovr1", ovr1, 0);
    q0.delete(); q1.delete();
    cs = 1'b1; sck = 1'b0; ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    cs_low(); push(8'h81); send_bits(8'h81, 8, 4, 4); cs_high(); tick(20);
    chk("t5 data0", data0, 8'h81);
    chk("t5 data1", data1, 8'h81);

    // 6: falling-edge instance on a distinct word, then random periods
    cs_low(); push(8'h5A); send_bits(8'h5A, 8, 4, 4); cs_high(); tick(20);
    chk("t6 data1", data1, 8'h5A);
    for (int f = 0; f < 10; f++) begin
      cs_low();
      for (int k = 0; k < 10; k++) begin
        p = $urandom_range(4, 20);
        w = 8'($urandom);
        push(w);
        send_bits(w, 8, p / 2, p - p / 2);
      end
      cs_high();
    end

    for (int k = 0; k < 1000 && (q0.size() != 0 || q1.size() != 0); k++) tick(1);
    chk("drain q0", q0.size(), 0);
    chk("drain q1", q1.size(), 0);
    chk("final fe count", fecnt0 + fecnt1, 2);
    chk("final ovr0", ovr0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
